// File: rtl/potentio_sample_scheduler_if.sv
// ADC conversion and averaged-result handshake bundle for the potentiometer scheduler.
interface potentio_sample_scheduler_if #(
  parameter int CH_W   = 2,
  parameter int DATA_W = 12
);
  logic              adc_start;
  logic [CH_W-1:0]   adc_ch;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              res_valid;
  logic              res_ready;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;

  modport master (
    output adc_start, adc_ch, res_valid, res_ch, res_data,
    input  adc_done, adc_data, res_ready
  );

  modport slave (
    input  adc_start, adc_ch, res_valid, res_ch, res_data,
    output adc_done, adc_data, res_ready
  );
endinterface

// File: rtl/potentio_sample_scheduler.sv
// Round-robin ADC sequencer: one enabled channel per sample tick, 2**AVG_LOG2 averaged conversions.
// Optional ADC watchdog enabled by defining POT_SCHED_TIMEOUT_EN.
module potentio_sample_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int AVG_LOG2    = 2,
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr,
  potentio_sample_scheduler_if.master bus
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSMP  = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_START, S_CONV, S_PUBLISH
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d, per_m1;
  logic [CH_W-1:0]     sel_ch_q, sel_ch_d, last_q, last_d;
  logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                tick, tmo_hit;
  logic [CH_W-1:0]     nxt_ch, hi_ch, lo_ch;
  logic                hi_found;

  assign per_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  // >= rather than == so shrinking the period mid-count still wraps promptly
  assign tick   = (tick_cnt_q >= per_m1);

  // Lowest set bit above the last-served channel, else lowest set bit overall.
  always_comb begin
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (ch_mask[j]) begin
        lo_ch = CH_W'(j);
        if (CH_W'(j) > last_q) begin
          hi_ch    = CH_W'(j);
          hi_found = 1'b1;
        end
      end
    end
    nxt_ch = hi_found ? hi_ch : lo_ch;
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + PERIOD_W'(1);
    sel_ch_d   = sel_ch_q;
    last_d     = last_q;
    smp_cnt_d  = smp_cnt_q;
    acc_d      = acc_q;
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        if (enable) state_d = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end else if (tick && (ch_mask != '0)) begin
          sel_ch_d = nxt_ch;
          last_d   = nxt_ch;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_CONV;
      S_CONV: begin
        if (bus.adc_done) begin
          acc_d     = acc_q + ACC_W'(bus.adc_data);
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          state_d   = (smp_cnt_q == CNT_W'(NSMP - 1)) ? S_PUBLISH : S_START;
        end else if (tmo_hit) begin
          // abandon the channel; pointer already sits on it so the next tick moves on
          acc_d     = '0;
          smp_cnt_d = '0;
          state_d   = S_WAIT_TICK;
        end
      end
      S_PUBLISH: begin
        if (bus.res_ready) begin
          acc_d     = '0;
          smp_cnt_d = '0;
          if (enable) begin
            state_d = S_WAIT_TICK;
          end else begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      sel_ch_q   <= '0;
      last_q     <= CH_W'(NUM_CH - 1);
      smp_cnt_q  <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sel_ch_q   <= sel_ch_d;
      last_q     <= last_d;
      smp_cnt_q  <= smp_cnt_d;
      acc_q      <= acc_d;
    end
  end

`ifdef POT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    tmo_cnt_d = (state_q == S_CONV) ? tmo_cnt_q + TMO_W'(1) : '0;
    tmo_hit   = (state_q == S_CONV) && !bus.adc_done &&
                (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    err_d     = err_q;
    if (err_clr) err_d = 1'b0;
    if (tmo_hit) err_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign bus.adc_start = (state_q == S_START);
  assign bus.adc_ch    = sel_ch_q;
  assign bus.res_valid = (state_q == S_PUBLISH);
  assign bus.res_ch    = sel_ch_q;
  assign bus.res_data  = acc_q[ACC_W-1:AVG_LOG2];
  assign busy          = (state_q == S_START) || (state_q == S_CONV) || (state_q == S_PUBLISH);

endmodule

// File: tb/tb_potentio_sample_scheduler.sv
// Randomized bench: ADC responder + result monitor feed queues; tasks compare against a round-robin/average model.
module tb_potentio_sample_scheduler;
  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 12;
  localparam int AVG_LOG2    = 2;
  localparam int PERIOD_W    = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NSMP        = 1 << AVG_LOG2;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } item_t;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic [NUM_CH-1:0]   ch_mask;
  logic                busy, timeout_err, err_clr;

  potentio_sample_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  potentio_sample_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2),
    .PERIOD_W(PERIOD_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .period(period),
    .ch_mask(ch_mask), .busy(busy), .timeout_err(timeout_err),
    .err_clr(err_clr), .bus(bus)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  item_t conv_q[$], res_q[$], exp_q[$];
  logic [CH_W-1:0] gch_q[$];
  logic [DATA_W-1:0] data_tbl[$];
  int start_cyc[$];
  bit resp_en = 1'b1;
  int data_mode = 0, rdy_mode = 0, dly_min = 2, dly_max = 2, rr_last = NUM_CH - 1;

  // ADC model: done after a random delay, data per mode (0: ch*100, 1: random, 2: table)
  initial begin
    bit pend; int dly; logic [CH_W-1:0] pch; logic [DATA_W-1:0] d;
    pend = 0; dly = 0; pch = '0;
    bus.adc_done = 1'b0; bus.adc_data = '0;
    forever begin
      @(negedge ACLK);
      bus.adc_done = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          pend = 0;
          if (resp_en) begin
            if (data_mode == 0) d = DATA_W'(int'(pch) * 100);
            else if (data_mode == 2 && data_tbl.size() > 0) d = data_tbl.pop_front();
            else d = DATA_W'($urandom);
            bus.adc_data = d;
            bus.adc_done = 1'b1;
            conv_q.push_back({pch, d});
          end
        end else dly--;
      end
      if (bus.adc_start === 1'b1) begin
        pend = 1; pch = bus.adc_ch;
        dly = int'($urandom_range(dly_max, dly_min));
        start_cyc.push_back(cyc);
      end
    end
  end

  // Result sink: drives res_ready per mode (0: always, 1: random, 2: never), records handshakes
  initial begin
    logic r;
    bus.res_ready = 1'b0;
    forever begin
      @(negedge ACLK);
      r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.res_ready = r;
      if (ARESETN && bus.res_valid === 1'b1 && r) res_q.push_back({bus.res_ch, bus.res_data});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  function automatic int rr_next(input int last, input logic [NUM_CH-1:0] m);
    int idx;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (last + i) % NUM_CH;
      if (m[idx[CH_W-1:0]]) return idx;
    end
    return last;
  endfunction

  // Expected results: channel from round-robin rule, data = floor(mean of that channel's conversions)
  task automatic build_expected(input logic [NUM_CH-1:0] m, input int n);
    item_t c, e; int sum; logic [CH_W-1:0] g;
    for (int r = 0; r < n; r++) begin
      rr_last = rr_next(rr_last, m);
      e.ch = CH_W'(rr_last); g = e.ch; sum = 0;
      for (int k = 0; k < NSMP; k++) begin
        if (conv_q.size() > 0) begin
          c = conv_q.pop_front(); sum += int'(c.data);
          if (c.ch !== e.ch) g = c.ch;
        end else g = 'x;
      end
      e.data = DATA_W'(sum >> AVG_LOG2);
      exp_q.push_back(e); gch_q.push_back(g);
    end
  endtask

  task automatic quiesce(output bit ok);
    int k;
    enable = 1'b0; k = 0;
    while (busy && k < 500) begin step(1); k++; end
    step(3);
    ok = !busy;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; enable = 1'b0; period = 16'd40; ch_mask = '0; err_clr = 1'b0;
    step(3);
    checks += 6;
    if (bus.adc_start !== 1'b0) begin failures++; $display("FAIL rst_adc_start got %b want 0", bus.adc_start); end
    if (bus.adc_ch !== '0) begin failures++; $display("FAIL rst_adc_ch got %0d want 0", bus.adc_ch); end
    if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
    if (bus.res_data !== '0) begin failures++; $display("FAIL rst_res_data got %0d want 0", bus.res_data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
    ARESETN = 1'b1;
    step(4);
    checks++;
    if (busy !== 1'b0 || bus.adc_start !== 1'b0) begin failures++; $display("FAIL idle_busy got %b want 0", busy); end
    rr_last = NUM_CH - 1;
    conv_q.delete(); res_q.delete(); start_cyc.delete();
  endtask

  task automatic test_round_robin();
    int k; bit ok; item_t e, o; logic [CH_W-1:0] g;
    ch_mask = 4'hF; period = 16'd40; data_mode = 0; dly_min = 2; dly_max = 2; rdy_mode = 0;
    start_cyc.delete(); enable = 1'b1;
    k = 0; while (res_q.size() < 8 && k < 800) begin step(1); k++; end
    quiesce(ok);
    checks += 2;
    if (res_q.size() < 8) begin failures++; $display("FAIL rr_count got %0d want 8", res_q.size()); end
    if (!ok) begin failures++; $display("FAIL rr_quiesce busy=%b want 0", busy); end
    // one channel per tick: first conversions 40 apart, conversions within a channel 4 apart
    for (int gi = 0; gi < 7 && start_cyc.size() >= 4 * gi + 5; gi++) begin
      checks += 2;
      if (start_cyc[4*gi+4] - start_cyc[4*gi] != 40) begin failures++;
        $display("FAIL rr_tick_spacing got %0d want 40", start_cyc[4*gi+4] - start_cyc[4*gi]); end
      if (start_cyc[4*gi+1] - start_cyc[4*gi] != 4) begin failures++;
        $display("FAIL rr_conv_spacing got %0d want 4", start_cyc[4*gi+1] - start_cyc[4*gi]); end
    end
    build_expected(ch_mask, res_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
      checks += 2;
      if (o !== e) begin failures++; $display("FAIL rr_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
      if (g !== e.ch) begin failures++; $display("FAIL rr_adc_ch got %0d want %0d", g, e.ch); end
    end
    checks++;
    if (conv_q.size() != 0) begin failures++; $display("FAIL rr_leftover_conv got %0d want 0", conv_q.size()); end
  endtask

  task automatic test_average();
    int k; bit ok; item_t e, o; logic [CH_W-1:0] g;
    ch_mask = 4'b0010; period = 16'd30; data_mode = 2; dly_min = 0; dly_max = 4; rdy_mode = 1;
    data_tbl = '{12'd10, 12'd11, 12'd12, 12'd13, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
    enable = 1'b1;
    k = 0; while (res_q.size() < 2 && k < 400) begin step(1); k++; end
    quiesce(ok);
    checks += 3;
    if (res_q.size() < 2) begin failures++; $display("FAIL avg_count got %0d want 2", res_q.size()); end
    else begin
      if (res_q[0].data !== 12'd11) begin failures++; $display("FAIL avg_10_13 got %0d want 11", res_q[0].data); end
      if (res_q[1].data !== 12'd4095) begin failures++; $display("FAIL avg_full_scale got %0d want 4095", res_q[1].data); end
    end
    build_expected(ch_mask, res_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
      checks += 2;
      if (o !== e) begin failures++; $display("FAIL avg_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
      if (g !== e.ch) begin failures++; $display("FAIL avg_adc_ch got %0d want %0d", g, e.ch); end
    end
    checks++;
    if (conv_q.size() != 0 || !ok) begin failures++; $display("FAIL avg_leftover_conv got %0d want 0", conv_q.size()); end
  endtask

  task automatic test_mask();
    int k, n0, busy_seen; bit ok; item_t e, o; logic [CH_W-1:0] g;
    ch_mask = 4'b0101; period = 16'd25; data_mode = 1; dly_min = 0; dly_max = 5; rdy_mode = 1;
    enable = 1'b1;
    k = 0; while (res_q.size() < 4 && k < 600) begin step(1); k++; end
    quiesce(ok);
    checks++;
    if (res_q.size() < 4 || !ok) begin failures++; $display("FAIL mask_count got %0d want 4", res_q.size()); end
    build_expected(ch_mask, res_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
      checks += 2;
      if (o !== e) begin failures++; $display("FAIL mask_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
      if (g !== e.ch) begin failures++; $display("FAIL mask_adc_ch got %0d want %0d", g, e.ch); end
    end
    // empty mask: ticks discarded, never busy
    ch_mask = '0; n0 = start_cyc.size(); busy_seen = 0; enable = 1'b1;
    for (int i = 0; i < 200; i++) begin step(1); if (busy !== 1'b0) busy_seen++; end
    checks += 2;
    if (start_cyc.size() != n0) begin failures++; $display("FAIL mask0_starts got %0d want 0", start_cyc.size() - n0); end
    if (busy_seen != 0) begin failures++; $display("FAIL mask0_busy got %0d busy cycles want 0", busy_seen); end
    enable = 1'b0; step(2);
  endtask

  task automatic test_backpressure();
    int k, n0, bad; bit ok; item_t e, o, snap; logic [CH_W-1:0] g;
    ch_mask = 4'hF; period = 16'd10; data_mode = 1; dly_min = 1; dly_max = 1; rdy_mode = 2;
    enable = 1'b1;
    k = 0; while (bus.res_valid !== 1'b1 && k < 300) begin step(1); k++; end
    checks++;
    if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got %b want 1", bus.res_valid); end
    snap = {bus.res_ch, bus.res_data}; n0 = start_cyc.size(); bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus.res_valid !== 1'b1 || {bus.res_ch, bus.res_data} !== snap || busy !== 1'b1) bad++;
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
    if (start_cyc.size() != n0) begin failures++; $display("FAIL bp_no_start got %0d starts want 0", start_cyc.size() - n0); end
    rdy_mode = 0;
    k = 0; while (res_q.size() < 3 && k < 400) begin step(1); k++; end
    quiesce(ok);
    checks += 2;
    if (res_q.size() < 3 || !ok) begin failures++; $display("FAIL bp_count got %0d want 3", res_q.size()); end
    else if (res_q[0] !== snap) begin failures++; $display("FAIL bp_first got data=%0d want %0d", res_q[0].data, snap.data); end
    build_expected(ch_mask, res_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
      checks += 2;
      if (o !== e) begin failures++; $display("FAIL bp_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
      if (g !== e.ch) begin failures++; $display("FAIL bp_adc_ch got %0d want %0d", g, e.ch); end
    end
  endtask

  task automatic test_reset_mid();
    int k, bad; bit ok; item_t e, o; logic [CH_W-1:0] g;
    ch_mask = 4'b0110; period = 16'd20; data_mode = 1; dly_min = 3; dly_max = 3; rdy_mode = 0;
    enable = 1'b1;
    k = 0; while (bus.adc_start !== 1'b1 && k < 200) begin step(1); k++; end
    ARESETN = 1'b0; enable = 1'b0;
    step(1);
    checks++;
    if ({bus.adc_start, bus.res_valid, busy, bus.res_data} !== '0) begin failures++;
      $display("FAIL rmid_in_reset got start=%b valid=%b busy=%b want 0", bus.adc_start, bus.res_valid, busy); end
    step(1); ARESETN = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if ({bus.adc_start, bus.res_valid, busy, bus.res_data, bus.adc_ch} !== '0) bad++;
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL rmid_late_done got %0d nonzero cycles want 0", bad); end
    if (res_q.size() != 0) begin failures++; $display("FAIL rmid_partial got %0d results want 0", res_q.size()); end
    conv_q.delete(); res_q.delete(); rr_last = NUM_CH - 1; dly_min = 0; dly_max = 3;
    enable = 1'b1;
    k = 0; while (res_q.size() < 2 && k < 300) begin step(1); k++; end
    quiesce(ok);
    checks++;
    if (res_q.size() < 2 || !ok) begin failures++; $display("FAIL rmid_count got %0d want 2", res_q.size()); end
    else if (res_q[0].ch !== CH_W'(1)) begin failures++; $display("FAIL rmid_first_ch got %0d want 1", res_q[0].ch); end
    build_expected(ch_mask, res_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
      checks += 2;
      if (o !== e) begin failures++; $display("FAIL rmid_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
      if (g !== e.ch) begin failures++; $display("FAIL rmid_adc_ch got %0d want %0d", g, e.ch); end
    end
  endtask

  task automatic test_timeout();
    int k, bad;
    ARESETN = 1'b0; enable = 1'b0; step(2); ARESETN = 1'b1;
    conv_q.delete(); res_q.delete(); rr_last = NUM_CH - 1;
    ch_mask = 4'b0011; period = 16'd20; resp_en = 1'b0; rdy_mode = 0; dly_min = 1; dly_max = 1;
    enable = 1'b1;
`ifdef POT_SCHED_TIMEOUT_EN
    begin
      bit ok; item_t e, o; logic [CH_W-1:0] g;
      bad = 0; k = 0;
      while (timeout_err !== 1'b1 && k < TIMEOUT_CYC + 200) begin
        step(1); k++;
        if (bus.res_valid !== 1'b0) bad++;
      end
      resp_en = 1'b1;
      checks += 2;
      if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_flag got %b want 1", timeout_err); end
      if (bad != 0) begin failures++; $display("FAIL tmo_no_publish got %0d valid cycles want 0", bad); end
      rr_last = rr_next(rr_last, ch_mask);
      k = 0; while (res_q.size() < 1 && k < 300) begin step(1); k++; end
      quiesce(ok);
      checks++;
      if (res_q.size() < 1 || !ok) begin failures++; $display("FAIL tmo_next_count got %0d want 1", res_q.size()); end
      build_expected(ch_mask, res_q.size());
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); g = gch_q.pop_front(); o = res_q.pop_front();
        checks += 2;
        if (o !== e) begin failures++; $display("FAIL tmo_result got ch=%0d data=%0d want ch=%0d data=%0d", o.ch, o.data, e.ch, e.data); end
        if (g !== e.ch) begin failures++; $display("FAIL tmo_adc_ch got %0d want %0d", g, e.ch); end
      end
      checks += 2;
      if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
      err_clr = 1'b1; step(1); err_clr = 1'b0;
      if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got %b want 0", timeout_err); end
    end
`else
    bad = 0;
    for (int i = 0; i < 2 * TIMEOUT_CYC + 22; i++) begin
      err_clr = 1'($urandom_range(1, 0));
      step(1);
      if (bus.res_valid !== 1'b0 || timeout_err !== 1'b0) bad++;
    end
    err_clr = 1'b0;
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL notmo_quiet got %0d bad cycles want 0", bad); end
    if (busy !== 1'b1) begin failures++; $display("FAIL notmo_waits got busy=%b want 1", busy); end
`endif
    ARESETN = 1'b0; enable = 1'b0; step(2); ARESETN = 1'b1; resp_en = 1'b1;
    step(2);
  endtask

  initial begin
    ARESETN = 1'b0; enable = 1'b0; period = 16'd40; ch_mask = '0; err_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_average();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
